// File: rtl/hit_resolver_if.sv
// Hit-detection bus between the hit detector / player FSMs (master) and the resolver (slave).
interface hit_resolver_if;
  logic       frame_tick;
  logic [1:0] hitresult;
  logic [3:0] p1_state;
  logic [3:0] p2_state;
  logic       round_start;
  logic [6:0] p1_health;
  logic [6:0] p2_health;
  logic       p1_stun;
  logic       p2_stun;
  logic       p1_hit_pulse;
  logic       p2_hit_pulse;
  logic [1:0] winner;
  logic       round_over;

  modport master (
    output frame_tick, hitresult, p1_state, p2_state, round_start,
    input  p1_health, p2_health, p1_stun, p2_stun,
           p1_hit_pulse, p2_hit_pulse, winner, round_over
  );

  modport slave (
    input  frame_tick, hitresult, p1_state, p2_state, round_start,
    output p1_health, p2_health, p1_stun, p2_stun,
           p1_hit_pulse, p2_hit_pulse, winner, round_over
  );
endinterface

// File: rtl/hit_resolver.sv
// Turns per-frame hitbox contact into damage, hitstun, KO detection and round sequencing.
module hit_resolver #(
  parameter int MAX_HEALTH     = 100,
  parameter int BASIC_DAMAGE   = 10,
  parameter int STUN_FRAMES    = 12,
  parameter int KO_HOLD_FRAMES = 60
) (
  input  logic           clk,
  input  logic           rst_n,
  hit_resolver_if.slave  bus
);
  localparam int STW = $clog2(STUN_FRAMES + 1);
  localparam int KOW = $clog2(KO_HOLD_FRAMES + 1);
  localparam logic [6:0]     HMAX  = 7'(MAX_HEALTH);
  localparam logic [6:0]     DMG   = 7'(BASIC_DAMAGE);
  localparam logic [STW-1:0] STUNL = STW'(STUN_FRAMES);
  localparam logic [KOW-1:0] KOL   = KOW'(KO_HOLD_FRAMES);

  typedef enum logic [1:0] {FIGHT, KO_HOLD, OVER} state_e;

  state_e         state_q, state_d;
  logic [6:0]     h1_q, h1_d, h2_q, h2_d;
  logic [STW-1:0] sc1_q, sc1_d, sc2_q, sc2_d;
  logic           l1_q, l1_d, l2_q, l2_d;
  logic           pu1_q, pu1_d, pu2_q, pu2_d;
  logic [1:0]     win_q, win_d;
  logic [KOW-1:0] ko_q, ko_d;
  logic           land1, land2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FIGHT;
      h1_q    <= HMAX;
      h2_q    <= HMAX;
      sc1_q   <= '0;
      sc2_q   <= '0;
      l1_q    <= 1'b0;
      l2_q    <= 1'b0;
      pu1_q   <= 1'b0;
      pu2_q   <= 1'b0;
      win_q   <= 2'b00;
      ko_q    <= '0;
    end else begin
      state_q <= state_d;
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      sc1_q   <= sc1_d;
      sc2_q   <= sc2_d;
      l1_q    <= l1_d;
      l2_q    <= l2_d;
      pu1_q   <= pu1_d;
      pu2_q   <= pu2_d;
      win_q   <= win_d;
      ko_q    <= ko_d;
    end
  end

  // Both landings use pre-update stun/latch state so a trade (11) hits both players.
  assign land1 = (state_q == FIGHT) && bus.frame_tick && bus.hitresult[1] && (sc2_q == '0) && !l1_q;
  assign land2 = (state_q == FIGHT) && bus.frame_tick && bus.hitresult[0] && (sc1_q == '0) && !l2_q;

  always_comb begin
    state_d = state_q;
    h1_d    = h1_q;
    h2_d    = h2_q;
    sc1_d   = sc1_q;
    sc2_d   = sc2_q;
    l1_d    = l1_q;
    l2_d    = l2_q;
    pu1_d   = 1'b0;
    pu2_d   = 1'b0;
    win_d   = win_q;
    ko_d    = ko_q;
    if (bus.round_start) begin
      state_d = FIGHT;
      h1_d    = HMAX;
      h2_d    = HMAX;
      sc1_d   = '0;
      sc2_d   = '0;
      l1_d    = 1'b0;
      l2_d    = 1'b0;
      win_d   = 2'b00;
      ko_d    = '0;
    end else if (bus.frame_tick) begin
      if (sc1_q != '0) sc1_d = sc1_q - 1'b1;
      if (sc2_q != '0) sc2_d = sc2_q - 1'b1;
      case (state_q)
        FIGHT: begin
          if (bus.p1_state < 4'd3) l1_d = 1'b0;
          if (bus.p2_state < 4'd3) l2_d = 1'b0;
          if (land1) begin
            h2_d  = (h2_q < DMG) ? 7'd0 : h2_q - DMG;
            sc2_d = STUNL;
            l1_d  = 1'b1;
            pu2_d = 1'b1;
          end
          if (land2) begin
            h1_d  = (h1_q < DMG) ? 7'd0 : h1_q - DMG;
            sc1_d = STUNL;
            l2_d  = 1'b1;
            pu1_d = 1'b1;
          end
          if (h1_d == 7'd0 || h2_d == 7'd0) begin
            win_d   = {h1_d == 7'd0, h2_d == 7'd0};
            state_d = KO_HOLD;
            ko_d    = KOL;
          end
        end
        KO_HOLD: begin
          if (ko_q <= 1) begin
            ko_d    = '0;
            state_d = OVER;
          end else begin
            ko_d = ko_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.p1_health    = h1_q;
    bus.p2_health    = h2_q;
    bus.p1_stun      = (sc1_q != '0);
    bus.p2_stun      = (sc2_q != '0);
    bus.p1_hit_pulse = pu1_q;
    bus.p2_hit_pulse = pu2_q;
    bus.winner       = win_q;
    bus.round_over   = (state_q == OVER);
  end
endmodule

// File: tb/tb_hit_resolver.sv
// Scoreboard bench: per-tick expectations queued at drive time, compared after the DUT updates.
module tb_hit_resolver;
  typedef struct packed {
    logic [6:0] h1;
    logic [6:0] h2;
    logic       s1;
    logic       s2;
    logic       pu1;
    logic       pu2;
    logic [1:0] win;
    logic       ro;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ft = 1'b0;
  logic [1:0] hitr = 2'b00;
  logic [3:0] st1 = 4'd0;
  logic [3:0] st2 = 4'd0;
  logic       rstart = 1'b0;
  logic       sel = 1'b0;
  logic       trig_d = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;
  exp_t       sb[$];
  exp_t       obs;
  exp_t       mon_e;

  always #5 clk = ~clk;

  hit_resolver_if bus10();
  hit_resolver_if bus30();

  assign bus10.frame_tick  = ft;
  assign bus10.hitresult   = hitr;
  assign bus10.p1_state    = st1;
  assign bus10.p2_state    = st2;
  assign bus10.round_start = rstart;
  assign bus30.frame_tick  = ft;
  assign bus30.hitresult   = hitr;
  assign bus30.p1_state    = st1;
  assign bus30.p2_state    = st2;
  assign bus30.round_start = rstart;

  hit_resolver u_dut10 (.clk(clk), .rst_n(rst_n), .bus(bus10.slave));
  hit_resolver #(.BASIC_DAMAGE(30)) u_dut30 (.clk(clk), .rst_n(rst_n), .bus(bus30.slave));

  always_comb begin
    if (sel)
      obs = '{bus30.p1_health, bus30.p2_health, bus30.p1_stun, bus30.p2_stun,
              bus30.p1_hit_pulse, bus30.p2_hit_pulse, bus30.winner, bus30.round_over};
    else
      obs = '{bus10.p1_health, bus10.p2_health, bus10.p1_stun, bus10.p2_stun,
              bus10.p1_hit_pulse, bus10.p2_hit_pulse, bus10.winner, bus10.round_over};
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t E(input int h1, input int h2, input logic s1, input logic s2,
                             input logic p1, input logic p2, input logic [1:0] w, input logic ro);
    E = '{7'(h1), 7'(h2), s1, s2, p1, p2, w, ro};
  endfunction

  task automatic tick(input logic f, input logic [1:0] hr, input logic [3:0] a, input logic [3:0] b,
                      input logic rs, input exp_t e);
    @(negedge clk);
    ft = f; hitr = hr; st1 = a; st2 = b; rstart = rs;
    sb.push_back(e);
    @(negedge clk);
    ft = 1'b0; rstart = 1'b0; hitr = 2'b00;
  endtask

  always @(posedge clk) trig_d <= ft | rstart;

  always @(negedge clk) begin
    if (trig_d) begin
      if (sb.size() == 0) chk("sb_underflow", 0, 1);
      else begin
        mon_e = sb.pop_front();
        chk("p1_health", obs.h1, mon_e.h1);
        chk("p2_health", obs.h2, mon_e.h2);
        chk("p1_stun", obs.s1, mon_e.s1);
        chk("p2_stun", obs.s2, mon_e.s2);
        chk("p1_hit_pulse", obs.pu1, mon_e.pu1);
        chk("p2_hit_pulse", obs.pu2, mon_e.pu2);
        chk("winner", obs.win, mon_e.win);
        chk("round_over", obs.ro, mon_e.ro);
      end
    end
  end

  initial begin
    int h;
    int exp_h[4];
    exp_h = '{70, 40, 10, 0};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_p1_health", obs.h1, 100);
    chk("rst_p2_health", obs.h2, 100);
    chk("rst_stun", {obs.s1, obs.s2}, 0);
    chk("rst_pulse", {obs.pu1, obs.pu2}, 0);
    chk("rst_winner", obs.win, 0);
    chk("rst_round_over", obs.ro, 0);

    // single hit then stun countdown
    tick(1, 2'b10, 4, 0, 0, E(100, 90, 0, 1, 0, 1, 0, 0));
    for (int j = 1; j <= 12; j++) tick(1, 2'b00, 4, 0, 0, E(100, 90, 0, j < 12, 0, 0, 0, 0));
    // latch holds across a long contact
    repeat (30) tick(1, 2'b10, 4, 0, 0, E(100, 90, 0, 0, 0, 0, 0, 0));
    tick(1, 2'b10, 0, 0, 0, E(100, 90, 0, 0, 0, 0, 0, 0));
    tick(1, 2'b10, 4, 0, 0, E(100, 80, 0, 1, 0, 1, 0, 0));
    // round_start beats a same-cycle hit
    tick(1, 2'b10, 4, 0, 1, E(100, 100, 0, 0, 0, 0, 0, 0));
    // trade
    tick(1, 2'b11, 4, 4, 0, E(90, 90, 1, 1, 1, 1, 0, 0));
    h = 90;
    while (h > 10) begin
      for (int j = 1; j <= 12; j++) tick(1, 2'b00, 0, 0, 0, E(h, h, j < 12, j < 12, 0, 0, 0, 0));
      h -= 10;
      tick(1, 2'b11, 4, 4, 0, E(h, h, 1, 1, 1, 1, 0, 0));
    end
    for (int j = 1; j <= 12; j++) tick(1, 2'b00, 0, 0, 0, E(10, 10, j < 12, j < 12, 0, 0, 0, 0));
    tick(1, 2'b11, 4, 4, 0, E(0, 0, 1, 1, 1, 1, 2'b11, 0));
    for (int j = 1; j <= 20; j++) tick(1, 2'b11, 4, 4, 0, E(0, 0, j < 12, j < 12, 0, 0, 2'b11, 0));
    // restart out of KO_HOLD, then confirm FIGHT accepts a hit
    tick(0, 2'b00, 0, 0, 1, E(100, 100, 0, 0, 0, 0, 0, 0));
    tick(1, 2'b10, 4, 0, 0, E(100, 90, 0, 1, 0, 1, 0, 0));
    // async reset while stunned and pulsing
    #2 rst_n = 1'b0;
    #1;
    chk("arst_p2_health", obs.h2, 100);
    chk("arst_p2_stun", obs.s2, 0);
    chk("arst_p2_pulse", obs.pu2, 0);
    chk("arst_winner", obs.win, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // damage 30: saturating KO, hold, OVER
    sel = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(1, 2'b10, 4, 0, 0, E(100, exp_h[k], 0, 1, 0, 1, (k == 3) ? 2'b01 : 2'b00, 0));
      if (k < 3)
        for (int j = 1; j <= 12; j++) tick(1, 2'b00, 0, 0, 0, E(100, exp_h[k], 0, j < 12, 0, 0, 0, 0));
    end
    for (int j = 1; j <= 60; j++) tick(1, 2'b01, 0, 4, 0, E(100, 0, 0, j < 12, 0, 0, 2'b01, j == 60));
    repeat (3) tick(1, 2'b01, 0, 4, 0, E(100, 0, 0, 0, 0, 0, 2'b01, 1));

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hit_resolver.md
Name: hit_resolver

Overview:
- Consumer side of the hit-detection interface.
- Samples the 2-bit hit result once per video frame and turns raw hitbox/hurtbox contact into game events: damage, hitstun timers, one-hit-per-attack latching, KO detection and round sequencing.
- Sits between the hit detector and the player FSMs/HUD. Feeds health bars and stun flags back to both players.

Parameters:
- MAX_HEALTH, 100, starting health per player (7-bit range).
- BASIC_DAMAGE, 10, health removed per landed basic attack.
- STUN_FRAMES, 12, hitstun duration in frames.
- KO_HOLD_FRAMES, 60, frames between KO and round_over assertion.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per video frame; all game logic advances only on it
- hitresult  in  2  bit1 = P1 hitbox touching P2 hurtbox; bit0 = P2 hitbox touching P1 hurtbox; 11 = both
- p1_state  in  4  P1 FSM state (0 idle, 1 fwd, 2 back, 3 atk start, 4 atk end, 5 atk pull)
- p2_state  in  4  P2 FSM state, same encoding
- round_start  in  1  pulse: begin a new round
- p1_health  out  7  P1 remaining health
- p2_health  out  7  P2 remaining health
- p1_stun  out  1  P1 in hitstun; P1 FSM must ignore inputs
- p2_stun  out  1  P2 in hitstun
- p1_hit_pulse  out  1  one-clk pulse when P1 takes damage
- p2_hit_pulse  out  1  one-clk pulse when P2 takes damage
- winner  out  2  01 P1 won, 10 P2 won, 11 double KO, 00 none
- round_over  out  1  high in OVER state

Behaviour:
- Reset (async, rst_n=0):
  - health = MAX_HEALTH for both players
  - stun = 0, stun counters = 0, landed latches = 0
  - pulses = 0, winner = 00, round_over = 0
  - FSM = FIGHT
- FSM states: FIGHT, KO_HOLD, OVER.
- FIGHT, on a frame_tick cycle:
  - P1 lands when hitresult[1]=1, p2_stun=0, and p1_landed=0. On landing:
    - p2_health -= BASIC_DAMAGE, saturating at 0
    - p2 stun counter = STUN_FRAMES, p2_stun=1
    - p1_landed=1
    - p2_hit_pulse high this cycle
  - P2 lands symmetrically via hitresult[0].
  - hitresult=11: both landings evaluated independently in the same cycle. Stun/latch checks use pre-update values.
  - Landed latch clears on any frame_tick where the owner's state < 3 (not attacking). One damage event per attack.
  - Stun counter decrements on each frame_tick when nonzero. Stun clears on the tick the counter reaches 0. A new hit while stunned is ignored; stun is not refreshed.
  - After the update, if any health = 0:
    - winner = 01 (p2_health=0 only), 10 (p1_health=0 only), 11 (both)
    - go to KO_HOLD, hold counter = KO_HOLD_FRAMES
- KO_HOLD:
  - hitresult ignored; health frozen; stun counters keep decrementing.
  - Counter decrements per frame_tick. At 0, go to OVER.
- OVER:
  - round_over=1; health and winner held.
- round_start (sampled every clk, not gated by frame_tick), in any state:
  - next cycle: health = MAX_HEALTH, stun/latches/counters cleared, winner=00, round_over=0, FSM=FIGHT
  - round_start wins over a same-cycle hit.
- No state change on cycles without frame_tick, except round_start and pulse deassertion.
- Pulses last exactly one clk.
- Health arithmetic: 7-bit; if health < BASIC_DAMAGE, result = 0, with no wrap.
- Input hitresult 00 or a hit while the defender is stunned: no effect.

Test Plan:
- Single hit: reset, 1 tick with hitresult=10 and p1_state=4 → p2_health 90, p2_stun=1, single p2_hit_pulse. p2_stun clears exactly after 12 more ticks.
- Latch: hold hitresult=10 for 30 ticks with p1_state=4 → only one hit (health 90). Then 1 tick with p1_state=0, then hitresult=10 again → 80.
- Simultaneous: hitresult=11, both states 4 → both health 90, both pulses in the same cycle, both stunned.
- Saturation/KO:
  - Set BASIC_DAMAGE=30, land 4 separate attacks on P2 → health 100, 70, 40, 10, 0 with no wrap, winner=01.
  - round_over rises after 60 further ticks.
  - Hits during KO_HOLD are ignored.
- Double KO: both players at 10 with damage 10, hitresult=11 → winner=11.
- Restart/reset mid-round:
  - round_start during KO_HOLD → full health, FSM FIGHT next cycle.
  - rst_n low mid-stun → outputs at reset values immediately, asynchronously.
